// File: rtl/control_unit_fft_iter_pipe_if.sv
// Control/status bundle between the FFT sequencer and the block that drives it.
interface control_unit_fft_iter_pipe_if #(
   parameter int LAYW = 3,
   parameter int BUTW = 4
);
   logic            EN;
   logic            START;
   logic            ABORT;
   logic [LAYW-1:0] LOG2N_CFG;
   logic            BUSY;
   logic            DONE;
   logic            RD;
   logic            BUT_STROB;
   logic            Wr;
   logic            ADDR_EN;
   logic            LAY_EN;
   logic            FIRST;
   logic            LAST;
   logic [LAYW-1:0] LAYER;
   logic [BUTW-1:0] BUTT;

   // Host side: issues requests, observes the sequencer.
   modport master (
      output EN, START, ABORT, LOG2N_CFG,
      input  BUSY, DONE, RD, BUT_STROB, Wr, ADDR_EN, LAY_EN, FIRST, LAST, LAYER, BUTT
   );

   // Sequencer side.
   modport slave (
      input  EN, START, ABORT, LOG2N_CFG,
      output BUSY, DONE, RD, BUT_STROB, Wr, ADDR_EN, LAY_EN, FIRST, LAST, LAYER, BUTT
   );
endinterface

// File: rtl/control_unit_fft_iter_pipe.sv
// Sequencer for an iterative radix-2 FFT with a single butterfly unit.
// Run-time FFT size, parameterised RAM read and butterfly latencies.
//
//  state   | meaning
//  --------+---------------------------------------------------
//  S_IDLE  | waiting for START, counters held at 0
//  S_READ  | RD=1 for one enabled cycle
//  S_RWAIT | RD_LAT enabled cycles of RAM read latency
//  S_STROB | BUT_STROB=1 for one enabled cycle
//  S_BWAIT | BUT_LAT enabled cycles of butterfly latency
//  S_WRITE | Wr=ADDR_EN=1, advance butterfly/layer counters
//  S_FIN   | DONE=1 for one enabled cycle
module control_unit_fft_iter_pipe #(
   parameter int LOG2N_MAX = 5,
   parameter int RD_LAT    = 2,
   parameter int BUT_LAT   = 1,
   parameter int LAYW      = $clog2(LOG2N_MAX + 1),
   parameter int BUTW      = LOG2N_MAX - 1
) (
   input  logic                         CLK,
   input  logic                         RST,
   control_unit_fft_iter_pipe_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_READ, S_RWAIT, S_STROB, S_BWAIT, S_WRITE, S_FIN
   } state_t;

   localparam logic [LAYW-1:0] NMAX    = LAYW'(LOG2N_MAX);
   localparam logic [2:0]      RW_INIT = (RD_LAT  > 0) ? 3'(RD_LAT  - 1) : 3'd0;
   localparam logic [2:0]      BW_INIT = (BUT_LAT > 0) ? 3'(BUT_LAT - 1) : 3'd0;

   state_t          state_q, state_d;
   logic [LAYW-1:0] n_q, n_d;
   logic [LAYW-1:0] layer_q, layer_d;
   logic [BUTW-1:0] butt_q, butt_d;
   logic [2:0]      wcnt_q, wcnt_d;
   logic [LAYW-1:0] cfg_n;

   logic busy_q, rd_q, strob_q, wr_q, layen_q, fin_q, first_q, last_q;

   // Index of the last butterfly in a layer for an FFT of size 2^n.
   function automatic logic [BUTW-1:0] f_bmax(input logic [LAYW-1:0] n);
      logic [BUTW:0] half;
      half = {{BUTW{1'b0}}, 1'b1} << (n - 1'b1);
      return half[BUTW-1:0] - 1'b1;
   endfunction

   // Out-of-range size requests fall back to the largest supported size.
   assign cfg_n = ((bus.LOG2N_CFG < LAYW'(2)) || (bus.LOG2N_CFG > NMAX)) ? NMAX : bus.LOG2N_CFG;

   // Next-state and counter update; nothing moves while EN is low.
   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      layer_d = layer_q;
      butt_d  = butt_q;
      wcnt_d  = wcnt_q;
      if (bus.EN) begin
         if (bus.ABORT) begin
            state_d = S_IDLE;
            layer_d = '0;
            butt_d  = '0;
            wcnt_d  = '0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  layer_d = '0;
                  butt_d  = '0;
                  if (bus.START) begin
                     n_d     = cfg_n;
                     state_d = S_READ;
                  end
               end
               S_READ: begin
                  if (RD_LAT == 0) begin
                     state_d = S_STROB;
                  end else begin
                     state_d = S_RWAIT;
                     wcnt_d  = RW_INIT;
                  end
               end
               S_RWAIT: begin
                  if (wcnt_q == 3'd0) state_d = S_STROB;
                  else                wcnt_d  = wcnt_q - 3'd1;
               end
               S_STROB: begin
                  if (BUT_LAT == 0) begin
                     state_d = S_WRITE;
                  end else begin
                     state_d = S_BWAIT;
                     wcnt_d  = BW_INIT;
                  end
               end
               S_BWAIT: begin
                  if (wcnt_q == 3'd0) state_d = S_WRITE;
                  else                wcnt_d  = wcnt_q - 3'd1;
               end
               S_WRITE: begin
                  if (butt_q == f_bmax(n_q)) begin
                     butt_d = '0;
                     // On the final layer the layer index stays put through FIN.
                     if (layer_q == n_q - 1'b1) begin
                        state_d = S_FIN;
                     end else begin
                        layer_d = layer_q + 1'b1;
                        state_d = S_READ;
                     end
                  end else begin
                     butt_d  = butt_q + 1'b1;
                     state_d = S_READ;
                  end
               end
               S_FIN:   state_d = S_IDLE;
               default: state_d = S_IDLE;
            endcase
         end
      end
   end

   // State, counters and Moore output flags, all decoded from the next state.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
         n_q     <= NMAX;
         layer_q <= '0;
         butt_q  <= '0;
         wcnt_q  <= '0;
         busy_q  <= 1'b0;
         rd_q    <= 1'b0;
         strob_q <= 1'b0;
         wr_q    <= 1'b0;
         layen_q <= 1'b0;
         fin_q   <= 1'b0;
         first_q <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         layer_q <= layer_d;
         butt_q  <= butt_d;
         wcnt_q  <= wcnt_d;
         busy_q  <= (state_d != S_IDLE) && (state_d != S_FIN);
         rd_q    <= (state_d == S_READ);
         strob_q <= (state_d == S_STROB);
         wr_q    <= (state_d == S_WRITE);
         layen_q <= (state_d == S_WRITE) && (butt_d == f_bmax(n_d)) && (layer_d != n_d - 1'b1);
         fin_q   <= (state_d == S_FIN);
         first_q <= (state_d != S_IDLE) && (layer_d == '0);
         last_q  <= (state_d != S_IDLE) && (layer_d == n_d - 1'b1);
      end
   end

   // Pulses are masked by EN so a held cycle never repeats a strobe.
   assign bus.RD        = rd_q    & bus.EN;
   assign bus.BUT_STROB = strob_q & bus.EN;
   assign bus.Wr        = wr_q    & bus.EN;
   assign bus.ADDR_EN   = wr_q    & bus.EN;
   assign bus.LAY_EN    = layen_q & bus.EN;
   assign bus.DONE      = fin_q   & bus.EN;
   assign bus.BUSY      = busy_q;
   assign bus.FIRST     = first_q;
   assign bus.LAST      = last_q;
   assign bus.LAYER     = layer_q;
   assign bus.BUTT      = butt_q;

endmodule
